// File: rtl/commit_trace_checker.sv
// In-order commit checker: buffers DUT and golden retire records, pops them in lock-step and compares.
// Define TRACE_MEM_CHECK_EN to also store and compare the store (mem_*) fields.
module commit_trace_checker #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       dut_valid,
    output logic                       dut_ready,
    input  logic [XLEN-1:0]            dut_pc,
    input  logic                       dut_rd_we,
    input  logic [4:0]                 dut_rd,
    input  logic [XLEN-1:0]            dut_rd_data,
    input  logic                       dut_mem_we,
    input  logic [XLEN-1:0]            dut_mem_addr,
    input  logic [XLEN-1:0]            dut_mem_wdata,
    input  logic                       gold_valid,
    output logic                       gold_ready,
    input  logic [XLEN-1:0]            gold_pc,
    input  logic                       gold_rd_we,
    input  logic [4:0]                 gold_rd,
    input  logic [XLEN-1:0]            gold_rd_data,
    input  logic                       gold_mem_we,
    input  logic [XLEN-1:0]            gold_mem_addr,
    input  logic [XLEN-1:0]            gold_mem_wdata,
    output logic                       mismatch,
    output logic                       error,
    output logic [XLEN-1:0]            first_err_pc,
    output logic                       skew_err,
    output logic [31:0]                compare_count,
    output logic [15:0]                mismatch_count,
    output logic [$clog2(DEPTH):0]     dut_level,
    output logic [$clog2(DEPTH):0]     gold_level
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int BASE_W = 2 * XLEN + 6;
`ifdef TRACE_MEM_CHECK_EN
    localparam int REC_W  = BASE_W + 1 + 2 * XLEN;
`else
    localparam int REC_W  = BASE_W;
`endif
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    typedef enum logic {RUN, FAULT} state_t;

    // Record layout: {[mem_wdata, mem_addr, mem_we,] rd_data, rd, rd_we, pc}; a write to x0 is dropped here.
    function automatic logic [BASE_W-1:0] pack_base(input logic [XLEN-1:0] pc, input logic rd_we,
                                                    input logic [4:0] rd, input logic [XLEN-1:0] rd_data);
        return {rd_data, rd, rd_we && (rd != 5'd0), pc};
    endfunction

    logic [1:0]       in_valid;
    logic [REC_W-1:0] in_rec   [2];
    logic [REC_W-1:0] rec_q    [2];
    logic [LVL_W-1:0] level_q  [2];
    logic [1:0]       empty_q;
    logic             pop;

    assign in_valid = {gold_valid, dut_valid};
`ifdef TRACE_MEM_CHECK_EN
    assign in_rec[0] = {dut_mem_wdata, dut_mem_addr, dut_mem_we,
                        pack_base(dut_pc, dut_rd_we, dut_rd, dut_rd_data)};
    assign in_rec[1] = {gold_mem_wdata, gold_mem_addr, gold_mem_we,
                        pack_base(gold_pc, gold_rd_we, gold_rd, gold_rd_data)};
`else
    logic unused_mem;
    assign unused_mem = ^{dut_mem_we, dut_mem_addr, dut_mem_wdata, gold_mem_we, gold_mem_addr, gold_mem_wdata};
    assign in_rec[0]  = pack_base(dut_pc, dut_rd_we, dut_rd, dut_rd_data);
    assign in_rec[1]  = pack_base(gold_pc, gold_rd_we, gold_rd, gold_rd_data);
`endif

    assign pop = !empty_q[0] && !empty_q[1] && !clear;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [REC_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] wr_ptr_reg;
            logic [PTR_W-1:0] rd_ptr_reg;
            logic [LVL_W-1:0] level_reg;
            logic [REC_W-1:0] head_reg;
            logic             push;

            assign push = in_valid[gi] && (level_reg != FULL_LVL) && !clear;

            // Storage and registered read port carry no reset so they map onto block RAM.
            always_ff @(posedge clk) begin
                if (push)
                    mem[wr_ptr_reg] <= in_rec[gi];
                if (pop)
                    head_reg <= mem[rd_ptr_reg];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else if (clear) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    level_reg  <= '0;
                end else begin
                    if (push)
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (pop)
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    if (push && !pop)
                        level_reg <= level_reg + LVL_W'(1);
                    else if (!push && pop)
                        level_reg <= level_reg - LVL_W'(1);
                end
            end

            assign level_q[gi] = level_reg;
            assign empty_q[gi] = (level_reg == '0);
            assign rec_q[gi]   = head_reg;
        end
    endgenerate

    state_t            state_reg, state_next;
    logic              cmp_valid_reg;
    logic              diff;
    logic              cmp_fail;
    logic              mismatch_reg;
    logic [XLEN-1:0]   first_err_pc_reg;
    logic [31:0]       compare_count_reg;
    logic [15:0]       mismatch_count_reg;
    logic [TMR_W-1:0]  skew_timer_reg;
    logic              skew_err_reg;

    // Bit XLEN is the normalised rd_we; rd/rd_data only matter when it is set.
    always_comb begin
        diff = (rec_q[0][XLEN:0] != rec_q[1][XLEN:0])
            || (rec_q[0][XLEN] && (rec_q[0][BASE_W-1:XLEN+1] != rec_q[1][BASE_W-1:XLEN+1]));
`ifdef TRACE_MEM_CHECK_EN
        diff = diff || (rec_q[0][BASE_W] != rec_q[1][BASE_W])
            || (rec_q[0][BASE_W] && (rec_q[0][REC_W-1:BASE_W+1] != rec_q[1][REC_W-1:BASE_W+1]));
`endif
    end

    assign cmp_fail = cmp_valid_reg && diff;

    always_comb begin
        state_next = state_reg;
        if (clear)
            state_next = RUN;
        else if (cmp_fail)
            state_next = FAULT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_valid_reg      <= 1'b0;
            mismatch_reg       <= 1'b0;
            first_err_pc_reg   <= '0;
            compare_count_reg  <= '0;
            mismatch_count_reg <= '0;
            skew_timer_reg     <= '0;
            skew_err_reg       <= 1'b0;
        end else if (clear) begin
            cmp_valid_reg      <= 1'b0;
            mismatch_reg       <= 1'b0;
            first_err_pc_reg   <= '0;
            compare_count_reg  <= '0;
            mismatch_count_reg <= '0;
            skew_timer_reg     <= '0;
            skew_err_reg       <= 1'b0;
        end else begin
            cmp_valid_reg <= pop;
            mismatch_reg  <= cmp_fail;
            if (cmp_valid_reg && (compare_count_reg != '1))
                compare_count_reg <= compare_count_reg + 32'd1;
            if (cmp_fail && (mismatch_count_reg != '1))
                mismatch_count_reg <= mismatch_count_reg + 16'd1;
            if (cmp_fail && (state_reg == RUN))
                first_err_pc_reg <= rec_q[0][XLEN-1:0];
            // Exactly one side non-empty means no pop can happen, so the timer runs.
            if (empty_q[0] ^ empty_q[1]) begin
                if (skew_timer_reg != TMR_LIMIT)
                    skew_timer_reg <= skew_timer_reg + TMR_W'(1);
                if (skew_timer_reg == TMR_LIMIT - TMR_W'(1))
                    skew_err_reg <= 1'b1;
            end else begin
                skew_timer_reg <= '0;
            end
        end
    end

    assign dut_ready      = (level_q[0] != FULL_LVL);
    assign gold_ready     = (level_q[1] != FULL_LVL);
    assign dut_level      = level_q[0];
    assign gold_level     = level_q[1];
    assign mismatch       = mismatch_reg;
    assign error          = (state_reg == FAULT);
    assign first_err_pc   = first_err_pc_reg;
    assign skew_err       = skew_err_reg;
    assign compare_count  = compare_count_reg;
    assign mismatch_count = mismatch_count_reg;
endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Parametrised in-order commit checker for the RISC-V core's verification harness. It sits beside the golden bundle and accepts one retired-instruction record per cycle from the DUT core and one from the golden model. Each stream is buffered in its own FIFO, and the two are popped and compared in lock-step. It reports per-record mismatches, a sticky error with the first failing PC, running counters and a skew-timeout fault.

## Interface
Parameters:
- XLEN, 32: data/address width of PC, register data and memory fields.
- DEPTH, 8: entries per FIFO; power of two, ≥ 2.
- TIMEOUT, 64: cycles one side may hold records while the other is empty before `skew_err` sets; ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear: flushes FIFOs and compare stage, zeroes counters and errors, returns the FSM to RUN.
- dut_valid / gold_valid  in  1  record offered.
- dut_ready / gold_ready  out  1  record accepted when valid && ready.
- dut_pc / gold_pc  in  XLEN  retired PC.
- dut_rd_we / gold_rd_we  in  1  register write.
- dut_rd / gold_rd  in  5  destination register.
- dut_rd_data / gold_rd_data  in  XLEN  written value.
- dut_mem_we / gold_mem_we  in  1  store retired.
- dut_mem_addr / gold_mem_addr  in  XLEN  store address.
- dut_mem_wdata / gold_mem_wdata  in  XLEN  store data.
- mismatch  out  1  one-cycle pulse per failing compare.
- error  out  1  sticky; set on the first mismatch.
- first_err_pc  out  XLEN  `dut_pc` of the first mismatch.
- skew_err  out  1  sticky timeout fault.
- compare_count  out  32  compares performed, saturating.
- mismatch_count  out  16  mismatches, saturating.
- dut_level / gold_level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Reset values.** All outputs 0. `dut_ready` and `gold_ready` are 1 after reset is released. The FSM is in RUN.
- **Push.**
  - `ready = !full`.
  - A push on a full FIFO never happens, even when a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full FIFO leaves the level unchanged.
- **Normalisation at push.** A record with `rd_we=1` and `rd=0` is stored as `rd_we=0`.
- **Pop.** Both FIFOs are popped together when both are non-empty. There is no fall-through.
- **Compare stage.** The popped records are registered, then checked. A mismatch occurs when any of these holds:
  - the PCs differ;
  - the `rd_we` values differ;
  - `rd_we=1` and either `rd` or `rd_data` differs;
  - memory fields differ (see Configuration).
- **FSM.**
  - RUN → FAULT on the first mismatch: set `error` and capture `first_err_pc`.
  - FAULT stays in FAULT. Compares continue, `mismatch` still pulses, counters still advance, and `first_err_pc` is held.
  - Any state → RUN on `clear`.
- **Counters.**
  - `compare_count` increments once per compare.
  - `mismatch_count` increments once per mismatch.
  - Both saturate at all-ones and never wrap.
- **Skew timer.**
  - Counts cycles in which exactly one FIFO is non-empty.
  - Resets to 0 whenever both FIFOs are empty or a pop occurs.
  - Reaching TIMEOUT sets `skew_err` (sticky) and holds the timer.
- **Clear precedence.** `clear` wins over a push, pop, mismatch or timeout in the same cycle. Nothing from that cycle is recorded.
- **Reset mid-operation.** Asserting `reset` discards all FIFO contents and any in-flight compare immediately.

## Timing
- A record pushed on edge N, with the partner record already present, is popped on edge N+1.
- `mismatch`, the counters, `error` and `first_err_pc` update on edge N+2. Push-to-verdict latency is 2 cycles.
- Sustained throughput is one compare per cycle with both sides streaming.
- `dut_ready` and `gold_ready` are registered-state functions only. There is no combinational path from any `valid` input.
- `skew_err` rises on the edge completing the TIMEOUT-th consecutive skewed cycle.

## Configuration
- **`TRACE_MEM_CHECK_EN` defined.** Compare also requires:
  - equal `mem_we`;
  - when `mem_we=1`, equal `mem_addr` and `mem_wdata`.
- **`TRACE_MEM_CHECK_EN` undefined.**
  - Memory fields are neither stored nor compared.
  - The `mem_*` ports remain present and are ignored.
  - Storage per FIFO entry shrinks accordingly.

## Test plan
- **Lock-step match.** Push 10 identical records on both sides in the same cycles → no `mismatch`; `compare_count`=10 two cycles after the last push; `error`=0.
- **Data mismatch.** Record 3 has `dut_rd_data`=0x5 and `gold_rd_data`=0x6 at PC 0x0000_0008 → single `mismatch` pulse; `error`=1; `first_err_pc`=0x8; `mismatch_count`=1; a later mismatch at PC 0x10 leaves `first_err_pc`=0x8.
- **x0 normalisation.** DUT `rd_we=1, rd=0, rd_data=0xFF`; golden `rd_we=0` → no mismatch.
- **Backpressure and skew.** With DEPTH=8 and TIMEOUT=64, push 8 DUT records and none golden → `dut_ready`=0, `dut_level`=8; after 64 skewed cycles `skew_err`=1. Then push golden records → all 8 compare clean.
- **Clear and reset mid-flight.** Assert `clear` in the same cycle as a mismatching pop → `error`=0, counters 0, levels 0. Assert `reset` with 4 entries queued → all outputs 0 and ready=1 after release.
- **Memory check.** With `TRACE_MEM_CHECK_EN`, `mem_addr` 0x100 vs 0x104 → mismatch. Without the macro, the same stimulus → no mismatch.
